mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Memory-stage controller that consumes the EX/MEM pipeline-register outputs. For loads and stores it runs a req/ack transaction on the data bus and stalls the upstream pipeline until the transaction completes. It registers results into the MEM/WB stage: ALU result, load data, PC and writeback controls. It sits between the EX/MEM register and the writeback stage, and is the only master on the data bus.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for bus_ack before abort (>=2)
CNT_W, 5, timeout counter width (must hold TIMEOUT-1)
RESET_PC, 32'h80000000, reset value of wb_pc

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ex_aluout  in  32  ALU result / memory address from EX/MEM
ex_databusB  in  32  store data from EX/MEM
ex_pc  in  32  PC from EX/MEM
ex_memrd  in  1  load request
ex_memwr  in  1  store request
ex_memtoreg  in  2  writeback source select
ex_regwr  in  1  register write enable
ex_wraddr  in  5  destination register
stall  out  1  hold EX/MEM and all earlier stages (combinational)
bus_req  out  1  bus request, held high while BUSY
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address
bus_wdata  out  32  store data
bus_rdata  in  32  load data, valid with bus_ack
bus_ack  in  1  one-cycle completion strobe
bus_err  out  1  one-cycle pulse: timeout or misaligned access
wb_aluout  out  32  registered ALU result
wb_rdata  out  32  registered load data
wb_pc  out  32  registered PC
wb_memtoreg  out  2  registered writeback select
wb_regwr  out  1  registered register write enable
wb_wraddr  out  5  registered destination register

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, timeout count=0, bus_req=0, bus_err=0.
  - All wb_* outputs = 0, except wb_pc=RESET_PC.
  - Reset asserted mid-BUSY drops bus_req immediately; no transaction completes.
- Definitions:
  - acc = ex_memrd | ex_memwr. If both are set, the access is treated as a store.
  - mis = acc & (ex_aluout[1:0] != 0).
- FSM states: IDLE, BUSY.
  - IDLE, acc & ~mis: go to BUSY, latch addr/wdata/we, count=0.
  - IDLE, mis: no bus cycle; complete immediately (done) with error.
  - IDLE, ~acc: pass-through.
  - BUSY, bus_ack: done, return to IDLE.
  - BUSY, count==TIMEOUT-1 and no ack: done with error, return to IDLE.
  - BUSY, otherwise: count+1.
- Bus outputs:
  - bus_req = (state==BUSY).
  - bus_addr, bus_we and bus_wdata come from registers and are stable for the whole BUSY period.
  - bus_addr = {ex_aluout[31:2],2'b00}.
  - bus_ack is ignored in IDLE.
- done = (BUSY & (bus_ack | timeout)) | (IDLE & mis).
- stall = acc & ~done. EX/MEM holds its value during a stall, so ex_* inputs stay stable.
- MEM/WB update on every clock edge:
  - ~acc: capture ex_* directly; wb_rdata=0.
  - done: capture ex_*, with wb_rdata = bus_rdata on ack, else 0.
    - Error with a load: wb_regwr forced 0.
    - Error with a store: no architectural effect.
  - Stall cycle (acc & ~done): insert a bubble: wb_regwr=0, wb_memtoreg=0, wb_wraddr=0. wb_pc/wb_aluout may update.
- Latency: a memory access stalls for at least 1 cycle.
  - Access present at cycle t; BUSY at t+1; earliest ack at t+1.
  - WB captures at the end of t+1.
- bus_err = registered pulse, high for the one cycle after done-with-error.
- Back-to-back accesses: after done, the next ex_* access is seen in IDLE on the following cycle; no idle gap is required.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding.
  - RESET_PC.
  - memtoreg encodings.
- One natural sub-module: mem_bus_timer (timeout counter with clear/enable, terminal-count output).

Test Plan:
- ALU op (memrd=memwr=0, regwr=1, wraddr=5, aluout=0x1234) -> stall never high; next cycle wb_aluout=0x1234, wb_regwr=1, wb_wraddr=5.
- Load addr 0x100, ack 3 cycles after req with rdata=0xDEADBEEF:
  - stall high 3 cycles and bus_req high 3 cycles.
  - Bubbles (wb_regwr=0) while stalled.
  - Then wb_rdata=0xDEADBEEF, wb_regwr=1.
- Store addr 0x200 data 0xA5A5A5A5, ack in the first BUSY cycle:
  - bus_we=1, bus_wdata=0xA5A5A5A5.
  - stall 1 cycle; no bus_err.
- Load with no ack and TIMEOUT=16:
  - bus_req high exactly 16 cycles.
  - bus_err pulse; wb_regwr=0, wb_rdata=0.
- Load addr 0x102 (misaligned) -> no bus_req, stall 0 cycles, bus_err pulse, wb_regwr=0.
- Reset asserted in the 2nd BUSY cycle:
  - bus_req drops immediately; wb_pc=0x80000000, all other wb_*=0.
  - After release the controller is in IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage.
//   state_t      : memory-controller FSM encoding
//   RESET_PC_DEF : reset value of the MEM/WB PC register
//   MTR_*        : writeback source select encodings (ex_memtoreg / wb_memtoreg)
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC  = 2'd2;

endpackage

// File: rtl/mem_bus_timer.sv
// Bus timeout counter.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : count up by one
//   count      : current count
//   tc         : terminal count, high when count == TIMEOUT-1
module mem_bus_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between the EX/MEM register and writeback.
// Loads/stores run a req/ack transaction on the data bus while the
// upstream pipeline is stalled; results are registered into MEM/WB.
//   ex_*       : EX/MEM register outputs (held stable while stall is high)
//   stall      : hold EX/MEM and earlier stages (combinational)
//   bus_*      : data-bus master side; req held for the whole BUSY period
//   bus_err    : one-cycle pulse after a timeout or misaligned access
//   wb_*       : MEM/WB register outputs
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_databusB,
    input  logic [31:0] ex_pc,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [1:0]  ex_memtoreg,
    input  logic        ex_regwr,
    input  logic [4:0]  ex_wraddr,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic [31:0] wb_aluout,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_pc,
    output logic [1:0]  wb_memtoreg,
    output logic        wb_regwr,
    output logic [4:0]  wb_wraddr
);

    state_t     state, state_nxt;
    logic       acc, mis, start, ack_hit, tmo_hit, done, err;
    logic       tc;
    logic [CNT_W-1:0] count;

    mem_bus_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_BUSY),
        .en    (state == ST_BUSY),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc       = ex_memrd | ex_memwr;
        mis       = acc & (ex_aluout[1:0] != 2'b00);
        start     = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Misaligned accesses never reach the bus; they retire at once with an error.
                if (mis) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else if (acc) begin
                    start     = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                ack_hit = bus_ack;
                // An ack on the terminal cycle wins over the timeout.
                tmo_hit = tc & ~bus_ack;
                if (ack_hit | tmo_hit) begin
                    done      = 1'b1;
                    err       = tmo_hit;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        stall = acc & ~done;
    end

    assign bus_req = (state == ST_BUSY);

    // Bus command registers: loaded on entry to BUSY, stable until the next access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
        end else if (start) begin
            bus_addr  <= {ex_aluout[31:2], 2'b00};
            bus_wdata <= ex_databusB;
            bus_we    <= ex_memwr;  // both set -> store
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus_err <= 1'b0;
        else
            bus_err <= err;
    end

    // MEM/WB register: bubble while stalled, otherwise capture the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_aluout   <= '0;
            wb_rdata    <= '0;
            wb_pc       <= RESET_PC;
            wb_memtoreg <= '0;
            wb_regwr    <= 1'b0;
            wb_wraddr   <= '0;
        end else begin
            wb_aluout <= ex_aluout;
            wb_pc     <= ex_pc;
            if (stall) begin
                wb_rdata    <= '0;
                wb_memtoreg <= '0;
                wb_regwr    <= 1'b0;
                wb_wraddr   <= '0;
            end else begin
                wb_rdata    <= ack_hit ? bus_rdata : 32'd0;
                wb_memtoreg <= ex_memtoreg;
                // A failed access must not write the register file.
                wb_regwr    <= ex_regwr & ~err;
                wb_wraddr   <= ex_wraddr;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_aluout, ex_databusB, ex_pc;
    logic        ex_memrd, ex_memwr, ex_regwr;
    logic [1:0]  ex_memtoreg;
    logic [4:0]  ex_wraddr;
    logic        stall, bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [31:0] wb_aluout, wb_rdata, wb_pc;
    logic [1:0]  wb_memtoreg;
    logic        wb_regwr;
    logic [4:0]  wb_wraddr;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .reset(reset),
        .ex_aluout(ex_aluout), .ex_databusB(ex_databusB), .ex_pc(ex_pc),
        .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_memtoreg(ex_memtoreg),
        .ex_regwr(ex_regwr), .ex_wraddr(ex_wraddr),
        .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_err(bus_err), .wb_aluout(wb_aluout), .wb_rdata(wb_rdata),
        .wb_pc(wb_pc), .wb_memtoreg(wb_memtoreg), .wb_regwr(wb_regwr),
        .wb_wraddr(wb_wraddr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // cycles the current instruction has been presented

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // Expected MEM/WB contents and bus_err for the current cycle.
    logic [31:0] e_alu, e_rdata, e_pc;
    logic [1:0]  e_mtr;
    logic        e_regwr, e_err, e_bubble;
    logic [4:0]  e_wa;

    always @(negedge clk) begin
        logic acc, mis, on_bus, tmo, ack_ok, dn, er;
        if (!reset) begin
            e_alu = 0; e_rdata = 0; e_pc = 32'h8000_0000; e_mtr = 0;
            e_regwr = 0; e_wa = 0; e_err = 0; e_bubble = 0;
        end else begin
            acc    = ex_memrd | ex_memwr;
            mis    = acc && (ex_aluout % 4 != 0);
            on_bus = acc && !mis && k >= 1;          // bus cycle n is presentation cycle n
            ack_ok = on_bus && bus_ack;
            tmo    = on_bus && !bus_ack && k == TIMEOUT;
            dn     = mis || ack_ok || tmo;
            er     = mis || tmo;

            check("stall", stall, acc && !dn);
            check("bus_req", bus_req, on_bus);
            if (on_bus) begin
                check("bus_addr", bus_addr, ex_aluout & 32'hFFFF_FFFC);
                check("bus_we", bus_we, ex_memwr);
                if (ex_memwr) check("bus_wdata", bus_wdata, ex_databusB);
            end
            check("bus_err", bus_err, e_err);
            check("wb_regwr", wb_regwr, e_regwr);
            check("wb_wraddr", wb_wraddr, e_wa);
            check("wb_memtoreg", wb_memtoreg, e_mtr);
            if (!e_bubble) begin
                check("wb_aluout", wb_aluout, e_alu);
                check("wb_pc", wb_pc, e_pc);
                check("wb_rdata", wb_rdata, e_rdata);
            end

            e_err = er;
            if (acc && !dn) begin
                e_bubble = 1; e_regwr = 0; e_mtr = 0; e_wa = 0;
            end else begin
                e_bubble = 0;
                e_alu = ex_aluout; e_pc = ex_pc; e_mtr = ex_memtoreg; e_wa = ex_wraddr;
                e_regwr = ex_regwr && !er;
                e_rdata = ack_ok ? bus_rdata : 32'd0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nop();
        ex_memrd = 0; ex_memwr = 0; ex_regwr = 0; ex_wraddr = 0; ex_memtoreg = 0;
        ex_aluout = 32'h0; ex_databusB = 32'h0; ex_pc = 32'h0;
        bus_ack = 0; bus_rdata = 32'h0; k = 0;
    endtask

    // Present one instruction (caller is just past a rising edge), hold it while
    // stalled, return just past the edge that retires it with a nop presented.
    task automatic run(input string nm, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] dat, input logic [31:0] pc,
                       input logic [1:0] mtr, input logic rg, input logic [4:0] wa,
                       input int ack_at, input logic [31:0] rdat,
                       input int x_stall, input int x_req);
        int ns, nr;
        bit fin;
        ns = 0; nr = 0; fin = 0;
        ex_memrd = rd; ex_memwr = wr; ex_aluout = alu; ex_databusB = dat; ex_pc = pc;
        ex_memtoreg = mtr; ex_regwr = rg; ex_wraddr = wa; k = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            bus_ack   = (ack_at > 0 && k == ack_at);
            bus_rdata = bus_ack ? rdat : (32'hBAD0_0000 | c);
            @(negedge clk);
            if (stall) ns++;
            if (bus_req) nr++;
            if (!stall) fin = 1;
            @(posedge clk); #1;
            k++;
        end
        if (!fin) begin
            bad++; total++;
            $display("FAIL %s: stall never released within 40 cycles", nm);
        end
        nop();
        check({nm, " stall_cycles"}, ns, x_stall);
        check({nm, " req_cycles"}, nr, x_req);
    endtask

    initial begin
        nop();
        reset = 0;
        @(posedge clk); @(negedge clk);
        check("rst wb_pc", wb_pc, 32'h8000_0000);
        check("rst wb_aluout", wb_aluout, 0);
        check("rst bus_req", bus_req, 0);
        check("rst bus_err", bus_err, 0);
        @(posedge clk); #1 reset = 1;

        // ALU op
        run("alu", 0, 0, 32'h1234, 0, 32'h1000, 2'd0, 1, 5'd5, 0, 0, 0, 0);
        @(negedge clk);
        check("alu wb_aluout", wb_aluout, 32'h1234);
        check("alu wb_regwr", wb_regwr, 1);
        check("alu wb_wraddr", wb_wraddr, 5);
        @(posedge clk); #1;

        // load, ack on 3rd bus cycle
        run("ld", 1, 0, 32'h100, 0, 32'h1004, 2'd1, 1, 5'd7, 3, 32'hDEADBEEF, 3, 3);
        @(negedge clk);
        check("ld wb_rdata", wb_rdata, 32'hDEADBEEF);
        check("ld wb_regwr", wb_regwr, 1);
        check("ld wb_wraddr", wb_wraddr, 7);
        @(posedge clk); #1;

        // store, ack on first bus cycle
        run("st", 0, 1, 32'h200, 32'hA5A5A5A5, 32'h1008, 2'd0, 0, 5'd0, 1, 0, 1, 1);
        @(negedge clk);
        check("st bus_err", bus_err, 0);
        @(posedge clk); #1;

        // load timeout
        run("tmo", 1, 0, 32'h104, 0, 32'h100C, 2'd1, 1, 5'd9, 0, 0, 16, 16);
        @(negedge clk);
        check("tmo bus_err", bus_err, 1);
        check("tmo wb_regwr", wb_regwr, 0);
        check("tmo wb_rdata", wb_rdata, 0);
        @(posedge clk); #1;

        // misaligned load
        run("mis", 1, 0, 32'h102, 0, 32'h1010, 2'd1, 1, 5'd3, 0, 0, 0, 0);
        @(negedge clk);
        check("mis bus_err", bus_err, 1);
        check("mis wb_regwr", wb_regwr, 0);
        @(posedge clk); #1;

        // both memrd and memwr: treated as a store
        run("rdwr", 1, 1, 32'h300, 32'h0BADF00D, 32'h1014, 2'd0, 0, 5'd0, 2, 32'h11, 2, 2);
        @(posedge clk); #1;

        // reset during the 2nd bus cycle
        ex_memrd = 1; ex_aluout = 32'h400; ex_pc = 32'h1018; ex_regwr = 1; ex_wraddr = 5'd4;
        ex_memtoreg = 2'd1; k = 0;
        @(negedge clk); @(posedge clk); #1 k = 1;
        @(negedge clk); @(posedge clk); #1 k = 2;
        @(negedge clk); #2 reset = 0;
        #1;
        check("rstmid bus_req", bus_req, 0);
        check("rstmid wb_pc", wb_pc, 32'h8000_0000);
        check("rstmid wb_regwr", wb_regwr, 0);
        check("rstmid wb_wraddr", wb_wraddr, 0);
        check("rstmid wb_rdata", wb_rdata, 0);
        nop();
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        check("post-rst bus_req", bus_req, 0);
        @(posedge clk); #1;

        // controller usable again from IDLE
        run("ld2", 1, 0, 32'h500, 0, 32'h101C, 2'd1, 1, 5'd12, 1, 32'h600DCAFE, 1, 1);
        @(negedge clk);
        check("ld2 wb_rdata", wb_rdata, 32'h600DCAFE);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
